// File: rtl/gray_code_stream_converter_if.sv
// rtl/gray_code_stream_converter_if.sv - valid/ready word stream bundle for the Gray converter
interface gray_code_stream_converter_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             step_err;

  // Producer/consumer side that feeds words and drains results
  modport master (
    output in_valid, mode, din, out_ready,
    input  in_ready, out_valid, dout, step_err
  );

  // Converter side
  modport slave (
    input  in_valid, mode, din, out_ready,
    output in_ready, out_valid, dout, step_err
  );
endinterface

// File: rtl/gray_code_stream_converter.sv
// rtl/gray_code_stream_converter.sv - registered per-word binary<->Gray converter with adjacency check
module gray_code_stream_converter #(
  parameter int WIDTH     = 4,
  parameter int CHECK_ADJ = 1
) (
  input logic                          clk,
  input logic                          rst,
  gray_code_stream_converter_if.slave  bus
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_dout;
  logic             r_step_err;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_gray;
  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_conv;
  logic             w_step_err_nxt;

  // The single output slot frees up whenever it is empty or being drained this cycle
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Binary->Gray: each bit is the XOR of itself and its upper neighbour, MSB passes through
  assign w_gray = bus.din ^ (bus.din >> 1);

  // Gray->binary: prefix XOR running down from the MSB, fully unrolled
  always_comb begin
    w_bin            = '0;
    w_bin[WIDTH-1]   = bus.din[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_bin[i] = bus.din[i] ^ w_bin[i+1];
    end
  end

  assign w_conv = bus.mode ? w_bin : w_gray;

  generate
    if (CHECK_ADJ != 0) begin : g_adj
      logic [WIDTH-1:0] r_hist;
      logic             r_have_hist;
      logic             r_last_mode;
      logic [WIDTH-1:0] w_diff;
      logic             w_multi_bit;

      // More than one set bit in the difference means the Gray step skipped codes
      assign w_diff      = bus.din ^ r_hist;
      assign w_multi_bit = (w_diff & (w_diff - WIDTH'(1))) != '0;
      // Only Gray words following a Gray word are judged; the first after a switch or reset is exempt
      assign w_step_err_nxt = bus.mode && r_have_hist && r_last_mode && w_multi_bit;

      // History of the last accepted input word and its direction
      always_ff @(posedge clk) begin
        if (rst) begin
          r_hist      <= '0;
          r_have_hist <= 1'b0;
          r_last_mode <= 1'b0;
        end else if (w_accept) begin
          r_hist      <= bus.din;
          r_have_hist <= 1'b1;
          r_last_mode <= bus.mode;
        end
      end
    end else begin : g_no_adj
      assign w_step_err_nxt = 1'b0;
    end
  endgenerate

  // Output slot: load on accept, empty on drain, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_step_err  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_dout      <= w_conv;
      r_step_err  <= w_step_err_nxt;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.step_err  = r_step_err;

endmodule
